// File: rtl/dmem_responder.sv
// Data-memory target with configurable wait states, byte-masked stores and a one-cycle response strobe.
// Define DMEM_BOUNDS_EN to add the err port and suppress out-of-range accesses instead of wrapping.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    input  logic        Stall_MW_DM,
    output logic        valid_DM,
    output logic [31:0] data_rd
`ifdef DMEM_BOUNDS_EN
    ,
    output logic        err
`endif
);

    // Handshake: a request is accepted in any IDLE cycle with cs=1; the response is
    // the single cycle with valid_DM=1; dropping Stall_MW_DM during WAIT cancels it.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [3:0]              mask_q, mask_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    oob_q, oob_d;
    logic                    valid_q, valid_d;
    logic [31:0]             rdata_q, rdata_d;

    logic                    req_wr;
    logic [3:0]              req_mask;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [31:0]             req_wdata;
    logic                    req_oob;
    logic                    addr_oob;
    logic                    enter_resp;
    logic                    mem_we;

    logic [31:0] mem [DEPTH];

`ifdef DMEM_BOUNDS_EN
    logic err_q, err_d;
    assign addr_oob = |addr[31:DEPTH_LOG2+2];
    assign err      = err_q;
`else
    assign addr_oob = 1'b0;
`endif

    // Byte offset is the load/store unit's business; upper bits only matter for bounds checking.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[1:0], addr[31:DEPTH_LOG2+2]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        oob_d      = oob_q;
        enter_resp = 1'b0;
        req_wr     = wr_q;
        req_mask   = mask_q;
        req_idx    = idx_q;
        req_wdata  = wdata_q;
        req_oob    = oob_q;
        unique case (state_q)
            S_IDLE: begin
                if (cs) begin
                    wr_d      = wr;
                    mask_d    = mask;
                    idx_d     = addr[DEPTH_LOG2+1:2];
                    wdata_d   = data_wr;
                    oob_d     = addr_oob;
                    // With no wait states the request goes straight to RESP on this edge,
                    // so the live inputs drive the memory access.
                    req_wr    = wr;
                    req_mask  = mask;
                    req_idx   = addr[DEPTH_LOG2+1:2];
                    req_wdata = data_wr;
                    req_oob   = addr_oob;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!Stall_MW_DM) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        valid_d = enter_resp;
        rdata_d = 32'h0;
        if (enter_resp && !req_wr && !req_oob) begin
            rdata_d = mem[req_idx];
        end
`ifdef DMEM_BOUNDS_EN
        err_d = enter_resp && req_oob;
`endif
        mem_we = enter_resp && req_wr && !req_oob;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            mask_q  <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            oob_q   <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
`ifdef DMEM_BOUNDS_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            oob_q   <= oob_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
`ifdef DMEM_BOUNDS_EN
            err_q   <= err_d;
`endif
        end
    end

    // Word array is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (req_mask[0]) mem[req_idx][7:0]   <= req_wdata[7:0];
            if (req_mask[1]) mem[req_idx][15:8]  <= req_wdata[15:8];
            if (req_mask[2]) mem[req_idx][23:16] <= req_wdata[23:16];
            if (req_mask[3]) mem[req_idx][31:24] <= req_wdata[31:24];
        end
    end

    assign valid_DM = valid_q;
    assign data_rd  = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked against a word-map model.
// Honours DMEM_BOUNDS_EN when defined.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DL = 10;
    localparam int W0 = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_v    [2];
    logic        wr_v    [2];
    logic [3:0]  mask_v  [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic        stall_v [2];
    logic        valid_v [2];
    logic [31:0] rdata_v [2];
`ifdef DMEM_BOUNDS_EN
    logic        err_v   [2];
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [int];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W0)) dut (
        .clk(clk), .rst(rst), .cs(cs_v[0]), .wr(wr_v[0]), .mask(mask_v[0]),
        .addr(addr_v[0]), .data_wr(wdata_v[0]), .Stall_MW_DM(stall_v[0]),
        .valid_DM(valid_v[0]), .data_rd(rdata_v[0])
`ifdef DMEM_BOUNDS_EN
        , .err(err_v[0])
`endif
    );

    dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .cs(cs_v[1]), .wr(wr_v[1]), .mask(mask_v[1]),
        .addr(addr_v[1]), .data_wr(wdata_v[1]), .Stall_MW_DM(stall_v[1]),
        .valid_DM(valid_v[1]), .data_rd(rdata_v[1])
`ifdef DMEM_BOUNDS_EN
        , .err(err_v[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_oob(input logic [31:0] a);
`ifdef DMEM_BOUNDS_EN
        return a[31:DL+2] != '0;
`else
        return 1'b0;
`endif
    endfunction

    // One complete transaction on unit u; called one time unit after a rising edge with the unit idle.
    task automatic access(input int u, input logic w, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd);
        int          lat;
        int          key;
        logic        oob;
        logic [31:0] cur;
        logic [31:0] exp_d;
        lat   = (u == 0) ? W0 : 0;
        key   = u * 4096 + int'(a[DL+1:2]);
        oob   = is_oob(a);
        exp_d = 32'h0;
        rd    = 32'h0;
        if (!oob) begin
            cur = model_mem.exists(key) ? model_mem[key] : 32'h0;
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
                end
                model_mem[key] = cur;
            end else begin
                exp_d = cur;
            end
        end
        exp_q.push_back(exp_d);

        cs_v[u] = 1'b1; wr_v[u] = w; mask_v[u] = m; addr_v[u] = a; wdata_v[u] = d;
        tick();
        cs_v[u] = 1'b0; wr_v[u] = 1'($urandom); mask_v[u] = 4'($urandom);
        addr_v[u] = $urandom; wdata_v[u] = $urandom;
        for (int k = 0; k <= lat + 1; k++) begin
            check($sformatf("valid u%0d k%0d", u, k), 32'(valid_v[u]), 32'(k == lat));
            if (k == lat) begin
                rd = rdata_v[u];
                check($sformatf("data u%0d a%h", u, a), rdata_v[u], exp_q.pop_front());
`ifdef DMEM_BOUNDS_EN
                check($sformatf("err u%0d a%h", u, a), 32'(err_v[u]), 32'(oob));
`endif
            end
            if (k <= lat) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [31:0] old5;
        logic [31:0] old6;
        logic [31:0] a;
        logic [19:0] hi;
        int          u;

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cs_v[i] = 1'b0; wr_v[i] = 1'b0; mask_v[i] = 4'h0;
            addr_v[i] = 32'h0; wdata_v[i] = 32'h0; stall_v[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset valid u%0d", i), 32'(valid_v[i]), 32'h0);
            check($sformatf("reset data u%0d", i), rdata_v[i], 32'h0);
`ifdef DMEM_BOUNDS_EN
            check($sformatf("reset err u%0d", i), 32'(err_v[i]), 32'h0);
`endif
        end
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 16; w++) begin
                access(i, 1'b1, 4'hF, 32'(w) << 2, $urandom, got);
            end
        end

        // Plain load of a preloaded word.
        access(0, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, got);
        access(0, 1'b0, 4'h0, 32'h10, 32'h0, got);
        check("plain_load", got, 32'hCAFE_F00D);

        // Masked store followed by a load of the same word.
        access(0, 1'b1, 4'hF, 32'h4, 32'h1122_3344, got);
        access(0, 1'b1, 4'b0101, 32'h4, 32'hAABB_CCDD, got);
        access(0, 1'b0, 4'h0, 32'h4, 32'h0, got);
        check("masked_store", got, 32'h11BB_33DD);

        // Empty mask store leaves the word alone but still responds.
        access(0, 1'b1, 4'h0, 32'h4, 32'hFFFF_FFFF, got);
        access(0, 1'b0, 4'h0, 32'h4, 32'h0, got);
        check("zero_mask", got, 32'h11BB_33DD);

        // Zero wait states, back-to-back with a store presented during RESP.
        access(1, 1'b1, 4'hF, 32'h8, 32'h2222_2222, got);
        access(1, 1'b1, 4'hF, 32'hC, 32'h3333_3333, got);
        access(1, 1'b1, 4'hF, 32'h4, 32'h1111_1111, got);
        cs_v[1] = 1'b1; wr_v[1] = 1'b0; mask_v[1] = 4'h0; addr_v[1] = 32'h8;
        tick();
        check("b2b first valid", 32'(valid_v[1]), 32'h1);
        check("b2b first data", rdata_v[1], 32'h2222_2222);
        wr_v[1] = 1'b1; mask_v[1] = 4'hF; addr_v[1] = 32'hC; wdata_v[1] = 32'hDEAD_BEEF;
        tick();
        check("b2b resp gap", 32'(valid_v[1]), 32'h0);
        wr_v[1] = 1'b0; mask_v[1] = 4'h0; addr_v[1] = 32'h4;
        tick();
        check("b2b second valid", 32'(valid_v[1]), 32'h1);
        check("b2b second data", rdata_v[1], 32'h1111_1111);
        cs_v[1] = 1'b0;
        tick();
        check("b2b after", 32'(valid_v[1]), 32'h0);
        access(1, 1'b0, 4'h0, 32'hC, 32'h0, got);
        check("b2b ignored store", got, 32'h3333_3333);

        // Abort in the first WAIT cycle.
        old5 = 32'h5A5A_0505;
        access(0, 1'b1, 4'hF, 32'h14, old5, got);
        cs_v[0] = 1'b1; wr_v[0] = 1'b1; mask_v[0] = 4'hF; addr_v[0] = 32'h14; wdata_v[0] = ~old5;
        tick();
        cs_v[0] = 1'b0; stall_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("abort valid k%0d", k), 32'(valid_v[0]), 32'h0);
            tick();
        end
        stall_v[0] = 1'b1;
        access(0, 1'b0, 4'h0, 32'h14, 32'h0, got);
        check("abort old value", got, old5);

        // Asynchronous reset during a store's WAIT.
        old6 = 32'h6666_1234;
        access(0, 1'b1, 4'hF, 32'h18, old6, got);
        cs_v[0] = 1'b1; wr_v[0] = 1'b1; mask_v[0] = 4'hF; addr_v[0] = 32'h18; wdata_v[0] = 32'h0BAD_0BAD;
        tick();
        cs_v[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_wait valid", 32'(valid_v[0]), 32'h0);
        check("rst_wait data", rdata_v[0], 32'h0);
        tick();
        #2 rst = 1'b1;
        tick();
        access(0, 1'b0, 4'h0, 32'h18, 32'h0, got);
        check("rst_wait word kept", got, old6);

        // Asynchronous reset during a load's RESP clears the outputs at once.
        cs_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 32'h18;
        tick();
        cs_v[0] = 1'b0;
        tick();
        tick();
        check("rst_resp valid before", 32'(valid_v[0]), 32'h1);
        check("rst_resp data before", rdata_v[0], old6);
        #2 rst = 1'b0;
        #1;
        check("rst_resp valid", 32'(valid_v[0]), 32'h0);
        check("rst_resp data", rdata_v[0], 32'h0);
        tick();
        #2 rst = 1'b1;
        tick();

        // Address wrap or bounds error above the array.
        access(0, 1'b1, 4'hF, 32'h0, 32'h5555_AAAA, got);
        access(0, 1'b0, 4'h0, 32'h1000, 32'h0, got);
`ifdef DMEM_BOUNDS_EN
        check("addr_1000", got, 32'h0);
`else
        check("addr_1000", got, 32'h5555_AAAA);
`endif

        // Randomized traffic on both units.
        for (int i = 0; i < 60; i++) begin
            u  = int'($urandom_range(0, 1));
            hi = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(1, 20'hF_FFFF)) : 20'h0;
            a  = {hi, 10'($urandom_range(0, 15)), 2'($urandom)};
            access(u, 1'($urandom), 4'($urandom), a, $urandom, got);
        end

        check("exp_q drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
